// File: rtl/spi_ram_cmd.sv
// Command-driven single-port RAM behind the SPI slave's serial-to-parallel stage.
// Define SPI_RAM_ADDR_AUTO_INC_EN to post-increment the addresses after each data command.
module spi_ram_cmd #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid,
   output logic       seq_err
);

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   cmd_e                 cmd;
   logic [7:0]           mem_q [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 wa_set_q, wa_set_d;
   logic                 ra_set_q, ra_set_d;
   logic [7:0]           dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 seq_err_q, seq_err_d;
   logic                 mem_we;

   assign cmd = cmd_e'(din[9:8]);

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      wa_set_d   = wa_set_q;
      ra_set_d   = ra_set_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      seq_err_d  = seq_err_q;
      mem_we     = 1'b0;
      if (rx_valid) begin
         unique case (cmd)
            CMD_WR_ADDR: begin
               wr_addr_d = din[ADDR_SIZE-1:0];
               wa_set_d  = 1'b1;
            end
            CMD_WR_DATA: begin
               mem_we = 1'b1;
               if (!wa_set_q) seq_err_d = 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
               wr_addr_d = wr_addr_q + 1'b1;
`endif
            end
            CMD_RD_ADDR: begin
               rd_addr_d = din[ADDR_SIZE-1:0];
               ra_set_d  = 1'b1;
            end
            CMD_RD_DATA: begin
               dout_d     = mem_q[rd_addr_q];
               tx_valid_d = 1'b1;
               if (!ra_set_q) seq_err_d = 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
               rd_addr_d = rd_addr_q + 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         wa_set_q   <= 1'b0;
         ra_set_q   <= 1'b0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         wa_set_q   <= wa_set_d;
         ra_set_q   <= ra_set_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         seq_err_q  <= seq_err_d;
      end
   end

   // NOTE: the array has no reset so it maps onto RAM macros; contents survive rst,
   // but a write sampled while rst is high must still be dropped.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem_q[wr_addr_q] <= din[7:0];
   end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;
   assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_cmd.sv
// Self-checking bench for spi_ram_cmd (16-word build) against a command-level reference model.
module tb_spi_ram_cmd;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] din = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] dout;
   logic       tx_valid;
   logic       seq_err;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0] m_mem [DEPTH];
   int         m_wr, m_rd;
   bit         m_wa, m_ra, m_tx, m_err;
   logic [7:0] m_dout;

   spi_ram_cmd #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .rx_valid (rx_valid),
      .dout     (dout),
      .tx_valid (tx_valid),
      .seq_err  (seq_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wr = 0; m_rd = 0; m_wa = 0; m_ra = 0;
      m_tx = 0; m_err = 0; m_dout = 8'h00;
   endtask

   task automatic model_step(input bit v, input bit [1:0] c, input bit [7:0] p);
      m_tx = 0;
      if (!v) return;
      case (c)
         2'b00: begin m_wr = p % DEPTH; m_wa = 1; end
         2'b01: begin
            if (!m_wa) m_err = 1;
            m_mem[m_wr] = p;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
            m_wr = (m_wr + 1) % DEPTH;
`endif
         end
         2'b10: begin m_rd = p % DEPTH; m_ra = 1; end
         default: begin
            if (!m_ra) m_err = 1;
            m_dout = m_mem[m_rd];
            m_tx = 1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
            m_rd = (m_rd + 1) % DEPTH;
`endif
         end
      endcase
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".tx"},   {7'd0, tx_valid}, {7'd0, m_tx});
      check({tag, ".err"},  {7'd0, seq_err},  {7'd0, m_err});
      check({tag, ".dout"}, dout, m_dout);
   endtask

   // One command: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input string tag, input bit v, input bit [1:0] c, input bit [7:0] p);
      @(negedge clk);
      rx_valid = v;
      din      = {c, p};
      @(posedge clk);
      #1;
      model_step(v, c, p);
      check_outputs(tag);
   endtask

   // Reset across one edge while offering a write that must be ignored.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b1;
      din      = {2'b01, 8'h77};
      @(posedge clk);
      #1;
      model_reset();
      check_outputs(tag);
      @(negedge clk);
      rst      = 1'b0;
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Fill every location so all later reads have defined contents.
      for (int i = 0; i < DEPTH; i++) begin
         step("fill_a", 1, 2'b00, 8'(i));
         step("fill_d", 1, 2'b01, 8'($urandom_range(255)));
      end
      step("fill_idle", 0, 2'b00, 8'h00);

      // Basic write then read
      do_reset("rst1");
      step("tp1_wa", 1, 2'b00, 8'h12);
      step("tp1_wd", 1, 2'b01, 8'hA5);
      step("tp1_ra", 1, 2'b10, 8'h12);
      step("tp1_rd", 1, 2'b11, 8'h00);
      check("tp1_dout_const", dout, 8'hA5);
      check("tp1_tx_const", {7'd0, tx_valid}, 8'h01);
      step("tp1_idle", 0, 2'b11, 8'h00);
      check("tp1_tx_drop", {7'd0, tx_valid}, 8'h00);
      check("tp1_hold", dout, 8'hA5);

      // Read without a read-address: sticky error
      do_reset("rst2");
      step("tp2_rd", 1, 2'b11, 8'h00);
      check("tp2_err_const", {7'd0, seq_err}, 8'h01);
      step("tp2_wa", 1, 2'b00, 8'h03);
      step("tp2_wd", 1, 2'b01, 8'h3C);
      step("tp2_ra", 1, 2'b10, 8'h03);
      step("tp2_rd2", 1, 2'b11, 8'h00);
      check("tp2_err_sticky", {7'd0, seq_err}, 8'h01);

      // Back-to-back reads
      do_reset("rst3");
      step("tp3_ra", 1, 2'b10, 8'h05);
      step("tp3_rd0", 1, 2'b11, 8'h00);
      step("tp3_rd1", 1, 2'b11, 8'h00);
      step("tp3_idle", 0, 2'b00, 8'h00);

      // Address wrap and truncation
      step("tp4_wa", 1, 2'b00, 8'h0F);
      step("tp4_wd0", 1, 2'b01, 8'h11);
      step("tp4_wd1", 1, 2'b01, 8'h22);
      step("tp4_ra15", 1, 2'b10, 8'h3F);
      step("tp4_rd15", 1, 2'b11, 8'h00);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
      check("tp4_mem15_const", dout, 8'h11);
`else
      check("tp4_mem15_const", dout, 8'h22);
`endif
      step("tp4_ra0", 1, 2'b10, 8'h00);
      step("tp4_rd0", 1, 2'b11, 8'h00);
      step("tp4_wa_trunc", 1, 2'b00, 8'h3F);
      step("tp4_wd_trunc", 1, 2'b01, 8'h5A);
      step("tp4_ra_t", 1, 2'b10, 8'h0F);
      step("tp4_rd_t", 1, 2'b11, 8'h00);
      check("tp4_trunc_const", dout, 8'h5A);

      // Asynchronous reset while tx_valid is high
      step("tp5_ra", 1, 2'b10, 8'h02);
      step("tp5_rd", 1, 2'b11, 8'h00);
      rst = 1'b1;
      #1;
      model_reset();
      check("tp5_async_tx", {7'd0, tx_valid}, 8'h00);
      check("tp5_async_dout", dout, 8'h00);
      check("tp5_async_err", {7'd0, seq_err}, 8'h00);
      @(negedge clk);
      rst      = 1'b0;
      rx_valid = 1'b0;
      step("tp5_ra2", 1, 2'b10, 8'h02);
      step("tp5_rd2", 1, 2'b11, 8'h00);

      // Idle bus with random din must change nothing
      for (int i = 0; i < 20; i++) begin
         r = 8'($urandom_range(255));
         step("tp6_idle", 0, 2'($urandom_range(3)), r);
      end
      for (int i = 0; i < DEPTH; i++) begin
         step("tp6_ra", 1, 2'b10, 8'(i));
         step("tp6_rd", 1, 2'b11, 8'h00);
      end

      // Random traffic
      do_reset("rst7");
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)));
      end
      for (int i = 0; i < DEPTH; i++) begin
         step("final_ra", 1, 2'b10, 8'(i));
         step("final_rd", 1, 2'b11, 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_ram_cmd.md
# spi_ram_cmd

Single-port synchronous RAM with a command front end, sitting directly downstream of the serial-to-parallel stage of the SPI slave. Consumes each completed 10-bit word (2-bit command + 8-bit payload) on a one-cycle `rx_valid` strobe. Executes address-latch, write and read operations, and returns read data as an 8-bit word with a one-cycle `tx_valid` strobe for the parallel-to-serial return path. Tracks command-sequence legality in a sticky error flag.

## Interface
- `MEM_DEPTH`, 256, number of 8-bit words; power of two, 2..256.
- `ADDR_SIZE`, 8, address width; equals log2(`MEM_DEPTH`).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  10  `din[9:8]` command, `din[7:0]` payload.
- `rx_valid`  in  1  `din` valid this cycle; one command per cycle.
- `dout`  out  8  read data.
- `tx_valid`  out  1  one-cycle strobe: `dout` holds fresh read data.
- `seq_err`  out  1  sticky flag: illegal command sequence seen since reset.

## Operation
- Internal state:
  - `wr_addr`, `rd_addr` (`ADDR_SIZE` bits).
  - Flags `wa_set`, `ra_set`: address latched since reset.
  - Memory array `mem[MEM_DEPTH]`.
- Commands act only on an edge where `rx_valid`=1. With `rx_valid`=0, no state changes and `tx_valid`=0.
- `00`, write-address: `wr_addr <= din[ADDR_SIZE-1:0]`, `wa_set <= 1`.
- `01`, write-data: `mem[wr_addr] <= din[7:0]`. If `wa_set`=0, the write still goes to the current `wr_addr` and `seq_err <= 1`.
- `10`, read-address: `rd_addr <= din[ADDR_SIZE-1:0]`, `ra_set <= 1`.
- `11`, read-data: `dout <= mem[rd_addr]`, `tx_valid <= 1`. `din[7:0]` is ignored. If `ra_set`=0, the read still goes to the current `rd_addr` and `seq_err <= 1`.
- Payload bits above `ADDR_SIZE` are ignored (truncated), not flagged.
- Single port: at most one memory access per cycle, guaranteed by one command per cycle.
- Reset values: `dout`=0, `tx_valid`=0, `seq_err`=0, `wr_addr`=0, `rd_addr`=0, `wa_set`=0, `ra_set`=0.
- Memory contents are not reset; they are retained across reset.
- `seq_err` clears only on reset.

## Timing
- Write-address, write-data and read-address take effect at the sampling edge; latency 1 cycle.
- Read-data: sampled at edge N; `dout` and `tx_valid`=1 visible after edge N. `tx_valid` drops after edge N+1 unless another read-data is sampled at N+1.
- Back-to-back reads hold `tx_valid` high continuously, with `dout` updating every cycle.
- `dout` holds its last read value when `tx_valid`=0.
- Write-data to `mem[A]` at edge N followed by read-data of A at edge N+1 returns the new value (no bypass needed; the write has completed).
- `rst` asserted at any time, including the cycle after a read-data: all outputs go to reset values immediately, without waiting for a clock edge. A pending `tx_valid` is lost.
- `rx_valid` asserted during `rst` is ignored.

## Configuration
- Macro: `SPI_RAM_ADDR_AUTO_INC_EN`.
- Defined:
  - After each write-data, `wr_addr <= wr_addr + 1`.
  - After each read-data, `rd_addr <= rd_addr + 1`.
  - Both wrap modulo `MEM_DEPTH`; wrap is not an error.
  - A new address command overrides the incremented value.
- Not defined: addresses change only on `00`/`10` commands; repeated data commands reuse the same address.

## Test plan
- Reset, then `00`+`0x12`, `01`+`0xA5`, `10`+`0x12`, `11` → after the `11` edge, `dout`=`0xA5` and `tx_valid`=1 for exactly one cycle; `seq_err`=0.
- After reset, `11` with no prior `10` → `dout`=`mem[0]`, `tx_valid`=1, `seq_err`=1 and stays 1 through later legal traffic until `rst`.
- Two consecutive `11` cycles after `10`+`0x05` → `tx_valid` high for 2 cycles. With the macro: data from `mem[5]` then `mem[6]`. Without the macro: `mem[5]` twice.
- With the macro and `MEM_DEPTH`=16: `00`+`0x0F`, then writes `0x11`, `0x22` → `mem[15]`=`0x11`, `mem[0]`=`0x22` (wrap). `00`+`0x3F` latches address 15 (upper bits truncated).
- Assert `rst` mid-sequence, in the cycle `tx_valid`=1 → `tx_valid`, `dout` and `seq_err` go to 0 immediately. A read of a previously written address after reset, with a legal `10`/`11` sequence, returns the retained value.
- `rx_valid`=0 with random `din` for 20 cycles → no change to `tx_valid`, `dout`, `seq_err` or memory.
